rf_text_pixel_shifter: RTL and testbench

//  Downstream of the text character-bitmap RAM. Latches the 64-bit glyph row (bmp) on each

---
 rtl/rf_text_pkg.sv | 32 +++
 rtl/rf_text_blink_ctr.sv | 33 +++
 rtl/rf_text_pixel_shifter.sv | 137 +++++++++++++
 tb/tb_rf_text_pixel_shifter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_text_pkg.sv
// Shared types and constants for the text pixel shifter.
package rf_text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAD   = 2'd2
  } state_e;

  // attr_i = {cursor, blink, underline, reverse}
  localparam int ATTR_REV   = 0;
  localparam int ATTR_UL    = 1;
  localparam int ATTR_BLINK = 2;
  localparam int ATTR_CURS  = 3;

  localparam int COLOR_W = 24;
  typedef logic [COLOR_W-1:0] color_t;

  // Per-character flags resolved once at load time
  typedef struct packed {
    logic rev;      // reverse video
    logic blank;    // char blink in its off phase
    logic ul_row;   // this scanline carries the underline
    logic cur_row;  // this scanline is inside a visible cursor
  } row_flags_t;

  function automatic logic in_range(input logic [5:0] v, input logic [5:0] lo,
                                    input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rf_text_blink_ctr.sv
// Frame counter producing the shared blink phase for cursor and character blink.
module rf_text_blink_ctr #(
  parameter int pBlinkFrames = 16
) (
  input  logic dot_clk_i,
  input  logic rst_ni,
  input  logic frame_i,
  output logic blink_ph_o
);

  localparam int CW = (pBlinkFrames > 1) ? $clog2(pBlinkFrames) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_ph;

  // Count frames; flip the phase every pBlinkFrames frames
  always_ff @(posedge dot_clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ph  <= 1'b0;
    end else if (frame_i) begin
      if (r_cnt == CW'(pBlinkFrames - 1)) begin
        r_cnt <= '0;
        r_ph  <= ~r_ph;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign blink_ph_o = r_ph;

endmodule

// File: rtl/rf_text_pixel_shifter.sv
// Serialises a latched glyph row to one coloured pixel per dot clock.
module rf_text_pixel_shifter
  import rf_text_pkg::*;
#(
  parameter int pColorWidth  = 24,
  parameter int pBlinkFrames = 16
) (
  input  logic                   dot_clk_i,
  input  logic                   rst_ni,
  input  logic                   ce_i,
  input  logic [63:0]            bmp_i,
  input  logic [5:0]             maxScanpix_i,
  input  logic [5:0]             scanline_i,
  input  logic [5:0]             ul_line_i,
  input  logic [pColorWidth-1:0] fg_i,
  input  logic [pColorWidth-1:0] bg_i,
  input  logic [3:0]             attr_i,
  input  logic [5:0]             curs_start_i,
  input  logic [5:0]             curs_end_i,
  input  logic                   curs_blink_en_i,
  input  logic                   frame_i,
  input  logic                   active_i,
  output logic [pColorWidth-1:0] rgb_o,
  output logic                   de_o,
  output logic                   underrun_o
);

  state_e                  r_state, w_state_nxt;
  logic [63:0]             r_row;
  logic [pColorWidth-1:0]  r_fg, r_bg;
  row_flags_t              r_flags, w_flags_ld;
  logic [5:0]              r_pix_cnt;
  logic [pColorWidth-1:0]  r_rgb, w_rgb_nxt;
  logic                    r_de, w_de_nxt;
  logic                    r_underrun, w_pad;
  logic                    w_blink_ph;
  logic                    w_load;
  logic [5:0]              w_idx;
  logic                    w_dot;

  rf_text_blink_ctr #(.pBlinkFrames(pBlinkFrames)) u_blink (
    .dot_clk_i  (dot_clk_i),
    .rst_ni     (rst_ni),
    .frame_i    (frame_i),
    .blink_ph_o (w_blink_ph)
  );

  // A strobe outside the active window is ignored
  assign w_load = ce_i & active_i;

  assign w_flags_ld.rev     = attr_i[ATTR_REV];
  assign w_flags_ld.blank   = attr_i[ATTR_BLINK] & w_blink_ph;
  assign w_flags_ld.ul_row  = attr_i[ATTR_UL] & (scanline_i == ul_line_i);
  assign w_flags_ld.cur_row = attr_i[ATTR_CURS]
                            & in_range(scanline_i, curs_start_i, curs_end_i)
                            & (~curs_blink_en_i | ~w_blink_ph);

  // Leftmost pixel sits at bit maxScanpix, so walk the row downwards
  assign w_idx = maxScanpix_i - r_pix_cnt;
  assign w_dot = ((r_row[w_idx] | r_flags.ul_row) & ~r_flags.blank)
               ^ (r_flags.rev ^ r_flags.cur_row);

  // State register
  always_ff @(posedge dot_clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: active_i dominates, then reload, then run-out into PAD
  always_comb begin
    w_state_nxt = r_state;
    if (!active_i)
      w_state_nxt = ST_IDLE;
    else if (ce_i)
      w_state_nxt = ST_SHIFT;
    else if (r_state == ST_SHIFT && r_pix_cnt >= maxScanpix_i)
      w_state_nxt = ST_PAD;
  end

  // Output decode: pixel colour for the current state, before the output register
  always_comb begin
    w_rgb_nxt = '0;
    w_de_nxt  = 1'b0;
    w_pad     = 1'b0;
    if (active_i) begin
      case (r_state)
        ST_SHIFT: begin
          w_rgb_nxt = w_dot ? r_fg : r_bg;
          w_de_nxt  = 1'b1;
        end
        ST_PAD: begin
          w_rgb_nxt = r_bg;
          w_de_nxt  = 1'b1;
          w_pad     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Row latch and pixel counter; counter holds at the last pixel once exhausted
  always_ff @(posedge dot_clk_i) begin
    if (!rst_ni) begin
      r_row     <= '0;
      r_fg      <= '0;
      r_bg      <= '0;
      r_flags   <= '0;
      r_pix_cnt <= '0;
    end else if (w_load) begin
      r_row     <= bmp_i;
      r_fg      <= fg_i;
      r_bg      <= bg_i;
      r_flags   <= w_flags_ld;
      r_pix_cnt <= '0;
    end else if (r_state == ST_SHIFT && r_pix_cnt < maxScanpix_i) begin
      r_pix_cnt <= r_pix_cnt + 6'd1;
    end
  end

  // Output register stage; underrun latches on any pad pixel
  always_ff @(posedge dot_clk_i) begin
    if (!rst_ni) begin
      r_rgb      <= '0;
      r_de       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_rgb <= w_rgb_nxt;
      r_de  <= w_de_nxt;
      if (w_pad) r_underrun <= 1'b1;
    end
  end

  assign rgb_o      = r_rgb;
  assign de_o       = r_de;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_rf_text_pixel_shifter.sv
// Self-checking bench: directed scenarios plus random traffic vs a queue model.
module tb_rf_text_pixel_shifter;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n, ce, cben, frame, active;
  logic [63:0] bmp;
  logic [5:0]  maxpix, scan, ul_line, cs, cend;
  logic [23:0] fg, bg;
  logic [3:0]  attr;
  logic [23:0] rgb_o;
  logic        de_o, underrun_o;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [23:0] m_q[$];
  logic [23:0] m_bg = '0;
  bit          m_idle = 1'b1;
  bit          m_ph = 1'b0;
  int          m_cnt = 0;
  bit          m_und = 1'b0;
  logic [23:0] e_rgb = '0;
  bit          e_de = 1'b0;
  logic [63:0] cap = '0;

  rf_text_pixel_shifter #(.pColorWidth(24), .pBlinkFrames(BF)) dut (
    .dot_clk_i       (clk),
    .rst_ni          (rst_n),
    .ce_i            (ce),
    .bmp_i           (bmp),
    .maxScanpix_i    (maxpix),
    .scanline_i      (scan),
    .ul_line_i       (ul_line),
    .fg_i            (fg),
    .bg_i            (bg),
    .attr_i          (attr),
    .curs_start_i    (cs),
    .curs_end_i      (cend),
    .curs_blink_en_i (cben),
    .frame_i         (frame),
    .active_i        (active),
    .rgb_o           (rgb_o),
    .de_o            (de_o),
    .underrun_o      (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: on a load, the whole character is expanded into a pixel queue;
  // each cycle pops one pixel, or emits background once the queue is empty.
  task automatic model_step();
    bit ph_now, ul, cur, d;
    ph_now = m_ph;
    if (!rst_n) begin
      m_idle = 1; m_q.delete(); m_ph = 0; m_cnt = 0; m_und = 0;
      e_rgb = '0; e_de = 0;
      return;
    end
    if (!active) begin
      e_rgb = '0; e_de = 0; m_idle = 1; m_q.delete();
    end else begin
      if (m_idle) begin
        e_rgb = '0; e_de = 0;
      end else if (m_q.size() > 0) begin
        e_rgb = m_q.pop_front(); e_de = 1;
      end else begin
        e_rgb = m_bg; e_de = 1; m_und = 1;
      end
      if (ce) begin
        m_q.delete();
        m_bg = bg;
        m_idle = 0;
        ul  = attr[1] && (scan == ul_line);
        cur = attr[3] && (scan >= cs) && (scan <= cend) && (!cben || !ph_now);
        for (int k = 0; k <= int'(maxpix); k++) begin
          d = bmp[int'(maxpix) - k] | ul;
          if (attr[2] && ph_now) d = 0;
          if (attr[0] ^ cur) d = !d;
          m_q.push_back(d ? fg : bg);
        end
      end
    end
    if (frame) begin
      if (m_cnt == BF - 1) begin m_cnt = 0; m_ph = !m_ph; end
      else m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("rgb", 32'(rgb_o), 32'(e_rgb));
    check("de", 32'(de_o), 32'(e_de));
    check("underrun", 32'(underrun_o), 32'(m_und));
    cap = {cap[62:0], (rgb_o == fg)};
  endtask

  task automatic run_chars(input int n, input int period);
    for (int c = 0; c < n; c++)
      for (int t = 0; t < period; t++) begin
        ce = (t == 0);
        tick();
      end
    ce = 0;
  endtask

  // emit the last pixel of the final character, then leave the active window
  task automatic end_burst(input string tag, input logic [11:0] pat);
    ce = 0;
    tick();
    check(tag, 32'(cap[11:0]), 32'(pat));
    active = 0;
    tick();
    active = 1;
  endtask

  initial begin
    rst_n = 0; ce = 0; cben = 0; frame = 0; active = 0;
    bmp = 64'h0A5A; maxpix = 6'd11; scan = 6'd0; ul_line = 6'd63;
    cs = 6'd0; cend = 6'd0; fg = 24'hFFFFFF; bg = 24'h000000; attr = 4'b0000;

    repeat (3) tick();
    check("rst_rgb", 32'(rgb_o), 32'h0);
    check("rst_de", 32'(de_o), 32'h0);
    check("rst_und", 32'(underrun_o), 32'h0);
    rst_n = 1;
    active = 1;

    // 1: plain glyph, gap-free
    run_chars(3, 12);
    check("t1_und", 32'(underrun_o), 32'h0);
    end_burst("t1_pat", 12'hA5A);

    // 2: reverse, then cursor cancelling reverse
    attr = 4'b0001;
    run_chars(2, 12);
    end_burst("t2_rev", 12'h5A5);
    attr = 4'b1001; cs = 6'd16; cend = 6'd17; scan = 6'd16;
    run_chars(2, 12);
    end_burst("t2_cur", 12'hA5A);

    // 3: underline row vs non-underline row
    attr = 4'b0010; ul_line = 6'd17; bmp = '0; scan = 6'd17;
    run_chars(2, 12);
    end_burst("t3_ul", 12'hFFF);
    scan = 6'd16;
    run_chars(2, 12);
    end_burst("t3_nul", 12'h000);

    // 4: slow strobe -> pad pixels and sticky underrun
    attr = 4'b0000; bmp = 64'h0A5A;
    run_chars(3, 14);
    check("t4_und", 32'(underrun_o), 32'h1);
    active = 0; tick(); active = 1;

    // 5: character blink follows the blink phase
    attr = 4'b0100;
    active = 0;
    repeat (2) begin frame = 1; tick(); frame = 0; tick(); end
    active = 1;
    run_chars(2, 12);
    end_burst("t5_off", 12'h000);
    active = 0;
    repeat (2) begin frame = 1; tick(); frame = 0; tick(); end
    active = 1;
    run_chars(2, 12);
    end_burst("t5_on", 12'hA5A);

    // 6: reset in the middle of a character
    attr = 4'b0000;
    ce = 1; tick(); ce = 0;
    repeat (6) tick();
    rst_n = 0; tick(); rst_n = 1;
    check("t6_de", 32'(de_o), 32'h0);
    check("t6_und", 32'(underrun_o), 32'h0);
    run_chars(2, 12);
    end_burst("t6_resume", 12'hA5A);

    // random traffic, including max=0 and max=63
    for (int seg = 0; seg < 40; seg++) begin
      int sel, period;
      active = 0; ce = 0;
      sel = $urandom_range(0, 3);
      maxpix = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd63 : 6'($urandom_range(1, 20));
      tick();
      active = 1;
      for (int c = 0; c < 8; c++) begin
        bmp = {$urandom(), $urandom()};
        fg = 24'($urandom()); bg = 24'($urandom());
        attr = 4'($urandom_range(0, 15));
        scan = 6'($urandom_range(0, 5)); ul_line = 6'($urandom_range(0, 5));
        cs = 6'($urandom_range(0, 5)); cend = 6'($urandom_range(0, 5));
        cben = 1'($urandom_range(0, 1));
        period = ($urandom_range(0, 2) != 0) ? int'(maxpix) + 1
                                             : $urandom_range(1, int'(maxpix) + 4);
        for (int t = 0; t < period; t++) begin
          ce     = (t == 0) || ($urandom_range(0, 40) == 0);
          frame  = ($urandom_range(0, 5) == 0);
          active = ($urandom_range(0, 60) != 0);
          rst_n  = ($urandom_range(0, 400) != 0);
          tick();
        end
      end
      ce = 0; frame = 0; rst_n = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
